// File: rtl/stream_mux_n_to_1.sv
// N-to-1 valid/ready stream multiplexer with one registered output stage.
// MODE=0 forwards the externally selected channel; MODE=1 arbitrates
// round-robin among valid channels, starting after the last accepted one.
module stream_mux_n_to_1 #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2,
  parameter int MODE   = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] data_in,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        data_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        out_src
);

  logic [WIDTH-1:0]  r_data;
  logic              r_out_valid;
  logic [SEL_W-1:0]  r_src;
  logic [SEL_W-1:0]  r_last_grant;

  logic              w_load_en;
  logic              w_ext_vld;
  logic              w_rr_vld;
  logic [SEL_W-1:0]  w_rr_idx;
  logic              w_gnt_vld;
  logic [SEL_W-1:0]  w_gnt_idx;
  logic [WIDTH-1:0]  w_gnt_data;

  // The output register can take a new word when empty or being drained.
  assign w_load_en = !r_out_valid || out_ready;

  // External select: out-of-range select values grant nothing.
  always_comb begin
    w_ext_vld = 1'b0;
    if (int'(sel) < NUM_IN) w_ext_vld = in_valid[sel];
  end

  // Round-robin search upward from the channel after the last grant, wrapping.
  always_comb begin
    int c;
    c        = 0;
    w_rr_vld = 1'b0;
    w_rr_idx = '0;
    for (int k = 1; k <= NUM_IN; k++) begin
      c = (int'(r_last_grant) + k) % NUM_IN;
      if (!w_rr_vld && in_valid[c]) begin
        w_rr_vld = 1'b1;
        w_rr_idx = SEL_W'(c);
      end
    end
  end

  // Pick the grant source according to the compile-time mode.
  always_comb begin
    if (MODE == 1) begin
      w_gnt_vld = w_rr_vld;
      w_gnt_idx = w_rr_idx;
    end else begin
      w_gnt_vld = w_ext_vld;
      w_gnt_idx = sel;
    end
  end

  // Granted channel's data slice.
  always_comb begin
    w_gnt_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (int'(w_gnt_idx) == i) w_gnt_data = data_in[i*WIDTH +: WIDTH];
    end
  end

  // One-hot ready to the granted channel only; forced low while in reset.
  always_comb begin
    in_ready = '0;
    if (rst_n && w_load_en && w_gnt_vld) in_ready = NUM_IN'(1) << w_gnt_idx;
  end

  // Output register and round-robin pointer; pointer moves only on acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data       <= '0;
      r_out_valid  <= 1'b0;
      r_src        <= '0;
      r_last_grant <= SEL_W'(NUM_IN - 1);
    end else if (w_load_en) begin
      if (w_gnt_vld) begin
        r_data       <= w_gnt_data;
        r_src        <= w_gnt_idx;
        r_out_valid  <= 1'b1;
        r_last_grant <= w_gnt_idx;
      end else begin
        r_out_valid  <= 1'b0;
      end
    end
  end

  assign data_out  = r_data;
  assign out_valid = r_out_valid;
  assign out_src   = r_src;

endmodule

// File: tb/tb_stream_mux_n_to_1.sv
// Directed bench: one external-select instance and one round-robin instance.
module tb_stream_mux_n_to_1;

  localparam int W = 8;
  localparam int N = 4;
  localparam int S = 2;

  logic           clk;
  logic           rst_n;

  logic [N*W-1:0] data_e;
  logic [N-1:0]   in_valid_e;
  logic [N-1:0]   in_ready_e;
  logic [S-1:0]   sel_e;
  logic [W-1:0]   data_out_e;
  logic           out_valid_e;
  logic           out_ready_e;
  logic [S-1:0]   out_src_e;

  logic [N*W-1:0] data_r;
  logic [N-1:0]   in_valid_r;
  logic [N-1:0]   in_ready_r;
  logic [S-1:0]   sel_r;
  logic [W-1:0]   data_out_r;
  logic           out_valid_r;
  logic           out_ready_r;
  logic [S-1:0]   out_src_r;

  int vectors;
  int miscompares;

  stream_mux_n_to_1 #(.WIDTH(W), .NUM_IN(N), .SEL_W(S), .MODE(0)) u_ext (
    .clk(clk), .rst_n(rst_n), .data_in(data_e), .in_valid(in_valid_e),
    .in_ready(in_ready_e), .sel(sel_e), .data_out(data_out_e),
    .out_valid(out_valid_e), .out_ready(out_ready_e), .out_src(out_src_e)
  );

  stream_mux_n_to_1 #(.WIDTH(W), .NUM_IN(N), .SEL_W(S), .MODE(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .data_in(data_r), .in_valid(in_valid_r),
    .in_ready(in_ready_r), .sel(sel_r), .data_out(data_out_r),
    .out_valid(out_valid_r), .out_ready(out_ready_r), .out_src(out_src_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_src;
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    data_e      = {8'd8, 8'd3, 8'd4, 8'd7};
    in_valid_e  = 4'b1111;
    sel_e       = 2'd0;
    out_ready_e = 1'b1;
    data_r      = {8'h13, 8'h12, 8'h11, 8'h10};
    in_valid_r  = 4'b0000;
    sel_r       = 2'd0;
    out_ready_r = 1'b1;

    // reset state
    tick();
    tick();
    chk("rst_valid", 32'(out_valid_e), 32'd0);
    chk("rst_data",  32'(data_out_e),  32'd0);
    chk("rst_src",   32'(out_src_e),   32'd0);
    chk("rst_ready", 32'(in_ready_e),  32'd0);
    rst_n = 1'b1;
    #1;

    // external select stepping 0..3
    sel_e = 2'd0; #1;
    chk("ext_rdy0", 32'(in_ready_e), 32'b0001);
    tick();
    chk("ext_d0", 32'(data_out_e), 32'd7);
    chk("ext_s0", 32'(out_src_e), 32'd0);
    chk("ext_v0", 32'(out_valid_e), 32'd1);
    sel_e = 2'd1; #1;
    chk("ext_rdy1", 32'(in_ready_e), 32'b0010);
    tick();
    chk("ext_d1", 32'(data_out_e), 32'd4);
    chk("ext_s1", 32'(out_src_e), 32'd1);
    sel_e = 2'd2;
    tick();
    chk("ext_d2", 32'(data_out_e), 32'd3);
    chk("ext_s2", 32'(out_src_e), 32'd2);
    sel_e = 2'd3;
    tick();
    chk("ext_d3", 32'(data_out_e), 32'd8);
    chk("ext_s3", 32'(out_src_e), 32'd3);

    // selected channel not valid: nothing accepted, output drains, data holds
    sel_e = 2'd2; in_valid_e = 4'b1011; #1;
    chk("inv_rdy", 32'(in_ready_e), 32'd0);
    tick();
    chk("inv_valid", 32'(out_valid_e), 32'd0);
    chk("inv_data",  32'(data_out_e),  32'd8);
    chk("inv_src",   32'(out_src_e),   32'd3);

    // backpressure
    in_valid_e = 4'b1111; sel_e = 2'd1;
    tick();
    chk("bp_load", 32'(data_out_e), 32'd4);
    out_ready_e = 1'b0; sel_e = 2'd2; #1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_rdy",   32'(in_ready_e),  32'd0);
      tick();
      chk("bp_data",  32'(data_out_e),  32'd4);
      chk("bp_src",   32'(out_src_e),   32'd1);
      chk("bp_valid", 32'(out_valid_e), 32'd1);
    end
    out_ready_e = 1'b1; #1;
    chk("bp_resume_rdy", 32'(in_ready_e), 32'b0100);
    tick();
    chk("bp_resume_data", 32'(data_out_e), 32'd3);
    chk("bp_resume_src",  32'(out_src_e),  32'd2);
    in_valid_e = 4'b0000;
    tick();
    chk("bp_drain", 32'(out_valid_e), 32'd0);

    // round-robin, all valid
    in_valid_r = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_src = k % 4;
      #1;
      chk("rr_rdy", 32'(in_ready_r), 32'(1) << exp_src);
      tick();
      chk("rr_src",   32'(out_src_r),   32'(exp_src));
      chk("rr_data",  32'(data_out_r),  32'(8'h10 + exp_src));
      chk("rr_valid", 32'(out_valid_r), 32'd1);
    end

    // round-robin, channels 1 and 3 only (last grant was 0)
    in_valid_r = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      exp_src = (k % 2 == 0) ? 1 : 3;
      #1;
      chk("rr13_rdy", 32'(in_ready_r), 32'(1) << exp_src);
      tick();
      chk("rr13_src",   32'(out_src_r),   32'(exp_src));
      chk("rr13_valid", 32'(out_valid_r), 32'd1);
    end

    // asynchronous reset while holding an unconsumed word
    out_ready_r = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid_r), 32'd0);
    chk("arst_data",  32'(data_out_r),  32'd0);
    chk("arst_src",   32'(out_src_r),   32'd0);
    chk("arst_rdy",   32'(in_ready_r),  32'd0);
    tick();
    rst_n = 1'b1; in_valid_r = 4'b1111; out_ready_r = 1'b1; #1;
    chk("post_rst_rdy", 32'(in_ready_r), 32'b0001);
    tick();
    chk("post_rst_src",  32'(out_src_r),  32'd0);
    chk("post_rst_data", 32'(data_out_r), 32'h10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
